dual_bit_capture: RTL and testbench

Two-channel bit capture buffer that sits between the pair of LVDS digitizers and the UART dump path. On an arm pulse it records a fixed-length window of the two 1-bit sample streams into block RAM, packs them four sample-pairs per byte, and then drains the window as a framed byte stream over a valid/ready handshake to the UART transmitter. Capture and readout are decoupled, so the window contains contiguous samples regardless of UART rate.

---
 rtl/bitdump_pkg.sv | 25 ++
 rtl/capture_ram.sv | 20 ++
 rtl/dual_bit_capture.sv | 115 +++++++++++
 tb/tb_dual_bit_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bitdump_pkg.sv
// Shared types and constants for the dual-channel bit capture buffer.
package bitdump_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  // Bit position of each channel inside a 2-bit sample pair.
  localparam int CH0_BIT = 0;
  localparam int CH1_BIT = 1;

  function automatic logic [1:0] pair_bits(input logic s0, input logic s1);
    logic [1:0] p;
    p          = '0;
    p[CH0_BIT] = s0;
    p[CH1_BIT] = s1;
    return p;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port byte RAM with registered read; contents are never reset.
module capture_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dual_bit_capture.sv
// Captures a window of two 1-bit streams into RAM (4 pairs/byte), then drains
// it as a framed byte stream (A5, 5A, window bytes) over valid/ready.
module dual_bit_capture
  import bitdump_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DECIM      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic       sig1,
  input  logic       arm,
  output logic [7:0] out_dat,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  localparam int N  = 1 << DEPTH_LOG2;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BW = DEPTH_LOG2 + 1;

  state_t                state, state_nxt;
  logic [DW-1:0]         dec_cnt;
  logic [1:0]            pk;
  logic [5:0]            pack;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [BW-1:0]         bidx, bidx_nxt;
  logic                  last_ld;
  logic                  start, strobe, we, load, fin;
  logic [7:0]            wdata, rdata, byte_sel;
  logic [DEPTH_LOG2-1:0] raddr;

  assign start  = (state == IDLE) && arm && !done;
  assign strobe = (state == CAPTURE) && (dec_cnt == DW'(DECIM - 1));
  assign we     = strobe && (pk == 2'd3);
  assign wdata  = {pair_bits(sig, sig1), pack};

  assign load = (state == DRAIN) && !last_ld && (!out_valid || out_ready);
  assign fin  = (state == DRAIN) && last_ld && out_valid && out_ready;

  // Address the byte that will be loaded next, so registered read data is
  // ready the cycle it is needed and RAM bytes stream without bubbles.
  assign bidx_nxt = load ? bidx + BW'(1) : bidx;
  assign raddr    = DEPTH_LOG2'(bidx_nxt - BW'(2));
  assign byte_sel = (bidx == BW'(0)) ? HDR0 :
                    (bidx == BW'(1)) ? HDR1 : rdata;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: if (we && (&wptr)) state_nxt = DRAIN;
      DRAIN:   if (fin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dec_cnt   <= '0;
      pk        <= '0;
      pack      <= '0;
      wptr      <= '0;
      bidx      <= '0;
      last_ld   <= 1'b0;
      out_dat   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= fin;
      if (start) begin
        dec_cnt <= '0;
        pk      <= '0;
        pack    <= '0;
        wptr    <= '0;
        bidx    <= '0;
        last_ld <= 1'b0;
      end else begin
        bidx <= bidx_nxt;
        if (state == CAPTURE) begin
          dec_cnt <= strobe ? '0 : dec_cnt + DW'(1);
          if (strobe) begin
            pk <= pk + 2'd1;
            if (!we) pack[{pk, 1'b0} +: 2] <= pair_bits(sig, sig1);
          end
          if (we) wptr <= wptr + DEPTH_LOG2'(1);
        end
      end
      if (load) begin
        out_dat   <= byte_sel;
        out_valid <= 1'b1;
        if (bidx == BW'(N + 1)) last_ld <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  capture_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dual_bit_capture.sv
// Directed bench: two instances (DECIM=1 and DECIM=3, 16-byte windows) share stimulus.
module tb_dual_bit_capture;

  localparam int DL = 4;
  localparam int NB = 1 << DL;

  logic       clk, rst, sig, sig1, arm_x, sel, out_ready;
  logic       arm1, arm3;
  logic [7:0] dat1, dat3;
  logic       v1, v3, busy1, busy3, done1, done3;
  logic [7:0] o_dat;
  logic       o_valid, o_busy, o_done;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] got[$];
  logic [7:0] ref_b[$];

  assign arm1    = sel ? 1'b0 : arm_x;
  assign arm3    = sel ? arm_x : 1'b0;
  assign o_dat   = sel ? dat3  : dat1;
  assign o_valid = sel ? v3    : v1;
  assign o_busy  = sel ? busy3 : busy1;
  assign o_done  = sel ? done3 : done1;

  dual_bit_capture #(.DEPTH_LOG2(DL), .DECIM(1)) u_dut (
    .clk(clk), .rst(rst), .sig(sig), .sig1(sig1), .arm(arm1),
    .out_dat(dat1), .out_valid(v1), .out_ready(out_ready), .busy(busy1), .done(done1));

  dual_bit_capture #(.DEPTH_LOG2(DL), .DECIM(3)) u_dut3 (
    .clk(clk), .rst(rst), .sig(sig), .sig1(sig1), .arm(arm3),
    .out_dat(dat3), .out_valid(v3), .out_ready(out_ready), .busy(busy3), .done(done3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] body);
    chk({tag, "_len"}, got.size(), NB + 2);
    for (int i = 0; i < got.size() && i < NB + 2; i++)
      chk($sformatf("%s_b%0d", tag, i), got[i],
          (i == 0) ? 8'hA5 : (i == 1) ? 8'h5A : body);
  endtask

  // mode 0: sig=1,sig1=0; mode 1: sig toggles (1 at first sample), sig1=1;
  // mode 2: sig=0, sig1 = 0,1,0,1 on successive DECIM=3 samples.
  task automatic run_frame(input bit s, input int mode, input int rdy_pct,
                           input bit extra, input int abort_n,
                           output int first_k, output bit timeout,
                           output int done_n, output bit busy_at_done,
                           output int stall_bad);
    bit         prev_stall;
    logic [7:0] prev_dat;
    sel = s; got.delete();
    first_k = 0; done_n = 0; stall_bad = 0; timeout = 1'b1; busy_at_done = 1'b1;
    sig = (mode == 0); sig1 = (mode == 1);
    arm_x = 1'b1;
    tick();
    arm_x = 1'b0;
    chk("busy_after_arm", o_busy, 1);
    prev_stall = 1'b0; prev_dat = 8'h00;
    for (int j = 1; j <= 4000; j++) begin
      if (abort_n > 0 && got.size() == abort_n) begin
        timeout = 1'b0;
        return;
      end
      if (prev_stall && (!o_valid || o_dat != prev_dat)) stall_bad++;
      if (o_valid && first_k == 0) first_k = j;
      if (o_done) begin
        done_n++; busy_at_done = o_busy; timeout = 1'b0;
      end
      if (mode == 1) sig = (j % 2 == 1);
      if (mode == 2) sig1 = (((j - 1) / 3) % 2 == 1);
      out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
      arm_x = extra && !o_done && ($urandom_range(15) == 0);
      if (o_valid && out_ready) got.push_back(o_dat);
      prev_stall = o_valid && !out_ready;
      prev_dat   = o_dat;
      if (o_done) break;
      tick();
    end
  endtask

  int fk, dn, sb;
  bit to, bad;

  initial begin
    rst = 1'b0; sig = 1'b0; sig1 = 1'b0; arm_x = 1'b0; sel = 1'b0; out_ready = 1'b0;

    // reset with random inputs, arm toggling
    for (int i = 0; i < 6; i++) begin
      sig = 1'($urandom); sig1 = 1'($urandom); arm_x = 1'($urandom);
      sel = 1'($urandom); out_ready = 1'($urandom);
      tick();
    end
    chk("rst_valid", v1, 0);
    chk("rst_dat", dat1, 8'h00);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_valid3", v3, 0);
    chk("rst_busy3", busy3, 0);
    arm_x = 1'b0; sel = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    chk("post_rst_busy", busy1, 0);
    chk("post_rst_busy3", busy3, 0);

    // A: constant pattern, no backpressure; arm coincident with done
    run_frame(1'b0, 0, 100, 1'b0, 0, fk, to, dn, bad, sb);
    chk("a_timeout", to, 0);
    chk("a_cap_len", (fk >= 4*NB + 1) && (fk <= 4*NB + 2), 1);
    check_frame("a", 8'h55);
    chk("a_done_n", dn, 1);
    chk("a_busy_at_done", bad, 0);
    arm_x = 1'b1;
    tick();
    arm_x = 1'b0;
    chk("a_done_pulse", o_done, 0);
    chk("a_arm_on_done", o_busy, 0);
    tick();

    // B: toggling sig, confirms first sample lands at t+1
    run_frame(1'b0, 1, 100, 1'b0, 0, fk, to, dn, bad, sb);
    chk("b_timeout", to, 0);
    check_frame("b", 8'hBB);
    chk("b_done_n", dn, 1);
    ref_b = got;
    tick(); tick();

    // C: DECIM=3, sig1 alternating per sample
    run_frame(1'b1, 2, 100, 1'b0, 0, fk, to, dn, bad, sb);
    chk("c_timeout", to, 0);
    chk("c_cap_len", (fk >= 12*NB + 1) && (fk <= 12*NB + 2), 1);
    check_frame("c", 8'h88);
    chk("c_done_n", dn, 1);
    chk("c_busy_at_done", bad, 0);
    tick(); tick();

    // D: ~30% ready with stray arm pulses, same data as B
    run_frame(1'b0, 1, 30, 1'b1, 0, fk, to, dn, bad, sb);
    arm_x = 1'b0; out_ready = 1'b1;
    chk("d_timeout", to, 0);
    chk("d_cap_len", (fk >= 4*NB + 1) && (fk <= 4*NB + 2), 1);
    chk("d_stall_hold", sb, 0);
    chk("d_done_n", dn, 1);
    check_frame("d", 8'hBB);
    chk("d_same_as_b", got == ref_b, 1);
    tick(); tick();

    // E: reset mid-drain after 5 bytes, then a fresh frame
    run_frame(1'b0, 0, 100, 1'b0, 5, fk, to, dn, bad, sb);
    chk("e_timeout", to, 0);
    rst = 1'b0;
    #1;
    chk("e_abort_valid", v1, 0);
    chk("e_abort_busy", busy1, 0);
    chk("e_abort_dat", dat1, 8'h00);
    tick();
    rst = 1'b1;
    tick();
    chk("e_idle_busy", busy1, 0);
    run_frame(1'b0, 0, 100, 1'b0, 0, fk, to, dn, bad, sb);
    chk("f_timeout", to, 0);
    check_frame("f", 8'h55);
    chk("f_done_n", dn, 1);
    tick();
    chk("f_busy_end", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
